qar_lin_rx: RTL

LIN slave receive engine for the QAR-Core UART/LIN peripheral. It sits between the synchronised `uart_rx` pin and the peripheral register file. It detects the LIN break field, validates the 0x55 sync byte, and captures the protected identifier. Response data bytes go into a small FIFO that the core drains over the register bus.

---
 rtl/qar_lin_rx.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/qar_lin_rx.sv
// qar_lin_rx: LIN slave receive engine.
// Synchronises rx, detects the break field, checks the 0x55 sync byte,
// captures the protected identifier and buffers response bytes in a FIFO.
// Optional feature macro: QAR_LIN_PID_PARITY_EN enables PID parity checking;
// without it every PID is accepted and pid_err stays 0.
// Handshake: rd_valid means the FIFO head is on rd_data; a cycle with
// rd_en high and rd_valid high consumes that entry. rd_en with rd_valid
// low is ignored.
module qar_lin_rx #(
  parameter int CLKS_PER_BIT_W = 16,
  parameter int BREAK_BITS     = 11,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      rx,
  input  logic [CLKS_PER_BIT_W-1:0] clks_per_bit,
  input  logic                      rd_en,
  input  logic                      status_clr,
  output logic [7:0]                rd_data,
  output logic                      rd_valid,
  output logic [15:0]               header,
  output logic                      header_valid,
  output logic [7:0]                status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {BR_IDLE, BR_START, BR_DATA, BR_STOP, BR_WAIT} br_state_t;
  typedef enum logic [2:0] {FR_HUNT, FR_DELIM, FR_SYNC, FR_PID, FR_DATA} fr_state_t;

  // synchroniser and edge detect
  logic rx_s1, rxs, rxs_q, fall;

  // break detector
  logic [19:0] low_cnt;
  logic [19:0] brk_thr;
  logic        brk_hit;

  // byte receiver
  br_state_t                 br_state, br_next;
  logic [CLKS_PER_BIT_W-1:0] br_cnt;
  logic [CLKS_PER_BIT_W-1:0] half;
  logic [2:0]                bit_idx;
  logic [7:0]                shreg;
  logic                      mid_start, bit_end;
  logic                      stb_set, stop_err;
  logic                      byte_stb;
  logic [7:0]                byte_data;

  // frame FSM
  fr_state_t fr_state, fr_next;
  logic      push, sync_err, pid_ok, pid_bad, pid_par_ok;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop_ok, do_push, overrun_set;

  // flags
  logic break_flag, overrun, frame_err, pid_err;

  assign fall      = rxs_q & ~rxs;
  assign brk_thr   = 20'(BREAK_BITS) * 20'(clks_per_bit);
  assign brk_hit   = enable && !rxs && (low_cnt == brk_thr);
  assign half      = clks_per_bit >> 1;
  assign mid_start = (br_cnt == half - CLKS_PER_BIT_W'(1));
  assign bit_end   = (br_cnt == clks_per_bit - CLKS_PER_BIT_W'(1));

  // two-flop synchroniser; idle line level is 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
      rxs_q <= rxs;
    end
  end

  // low-time counter, saturating so brk_hit fires once per low period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) low_cnt <= '0;
    else if (!enable || rxs) low_cnt <= '0;
    else if (low_cnt != 20'hFFFFF) low_cnt <= low_cnt + 20'd1;
  end

  // byte receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) br_state <= BR_IDLE;
    else        br_state <= br_next;
  end

  // byte receiver next state; a low stop bit waits in BR_WAIT to see
  // whether the line turns into a break before calling it a framing error
  always_comb begin
    br_next  = br_state;
    stb_set  = 1'b0;
    stop_err = 1'b0;
    case (br_state)
      BR_IDLE:  if (fall) br_next = BR_START;
      BR_START: if (mid_start) br_next = rxs ? BR_IDLE : BR_DATA;
      BR_DATA:  if (bit_end && bit_idx == 3'd7) br_next = BR_STOP;
      BR_STOP: begin
        if (bit_end) begin
          if (rxs) begin
            stb_set = 1'b1;
            br_next = BR_IDLE;
          end else begin
            br_next = BR_WAIT;
          end
        end
      end
      BR_WAIT: begin
        if (rxs) begin
          stop_err = 1'b1;
          br_next  = BR_IDLE;
        end
      end
      default: br_next = BR_IDLE;
    endcase
    if (!enable || brk_hit) begin
      br_next  = BR_IDLE;
      stb_set  = 1'b0;
      stop_err = 1'b0;
    end
  end

  // bit timing counter, shift register and registered byte strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
      byte_data <= '0;
    end else begin
      if (br_next != br_state || bit_end || br_state == BR_IDLE || br_state == BR_WAIT)
        br_cnt <= '0;
      else
        br_cnt <= br_cnt + CLKS_PER_BIT_W'(1);
      if (br_state == BR_START) bit_idx <= '0;
      if (br_state == BR_DATA && bit_end) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      byte_stb <= stb_set;
      if (stb_set) byte_data <= shreg;
    end
  end

  // PID parity check, only when the feature is built in
`ifdef QAR_LIN_PID_PARITY_EN
  assign pid_par_ok = (byte_data[6] == (byte_data[0] ^ byte_data[1] ^ byte_data[2] ^ byte_data[4])) &&
                      (byte_data[7] == ~(byte_data[1] ^ byte_data[3] ^ byte_data[4] ^ byte_data[5]));
`else
  assign pid_par_ok = 1'b1;
`endif

  // frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fr_state <= FR_HUNT;
    else        fr_state <= fr_next;
  end

  // frame FSM next state; a break restarts the frame from any state
  always_comb begin
    fr_next  = fr_state;
    push     = 1'b0;
    sync_err = 1'b0;
    pid_ok   = 1'b0;
    pid_bad  = 1'b0;
    case (fr_state)
      FR_DELIM: if (rxs) fr_next = FR_SYNC;
      FR_SYNC: begin
        if (byte_stb) begin
          if (byte_data == 8'h55) begin
            fr_next = FR_PID;
          end else begin
            sync_err = 1'b1;
            fr_next  = FR_HUNT;
          end
        end
      end
      FR_PID: begin
        if (byte_stb) begin
          if (pid_par_ok) begin
            pid_ok  = 1'b1;
            fr_next = FR_DATA;
          end else begin
            pid_bad = 1'b1;
            fr_next = FR_HUNT;
          end
        end
      end
      FR_DATA: if (byte_stb) push = 1'b1;
      default: ;
    endcase
    if (!enable) begin
      fr_next  = FR_HUNT;
      push     = 1'b0;
      sync_err = 1'b0;
      pid_ok   = 1'b0;
      pid_bad  = 1'b0;
    end else if (brk_hit) begin
      fr_next  = FR_DELIM;
      push     = 1'b0;
      sync_err = 1'b0;
      pid_ok   = 1'b0;
      pid_bad  = 1'b0;
    end
  end

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign pop_ok      = rd_en && !empty;
  assign do_push     = push && (!full || pop_ok);
  assign overrun_set = push && full && !pop_ok;

  // FIFO storage; contents need no reset since rd_data is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= byte_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop_ok)      count <= count + CW'(1);
      else if (!do_push && pop_ok) count <= count - CW'(1);
    end
  end

  // sticky flags and header; a set in the same cycle as status_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      break_flag   <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
      pid_err      <= 1'b0;
      header_valid <= 1'b0;
      header       <= '0;
    end else begin
      break_flag   <= brk_hit | (break_flag & ~status_clr);
      overrun      <= overrun_set | (overrun & ~status_clr);
      frame_err    <= stop_err | sync_err | (frame_err & ~status_clr);
      pid_err      <= pid_bad | (pid_err & ~status_clr);
      header_valid <= pid_ok | (header_valid & ~status_clr);
      if (pid_ok) header <= {byte_data, 8'h55};
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];
  assign status   = {break_flag, header_valid, overrun, frame_err, pid_err, 3'b000};

endmodule
